fir_n_tap: RTL and testbench

Parametrised, signed, pipelined N-tap transposed-input FIR slice. It is the next-generation replacement for the fixed 4-tap slice in the FPGA signal path.
- Adds signed fixed-point arithmetic, saturation, a valid-qualified pipeline and a runtime-loadable double-buffered coefficient bank.
- Keeps sample/accumulator cascade ports so slices chain into longer filters.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_coeff_bank.sv | 52 +++++
 rtl/fir_n_tap.sv | 141 ++++++++++++++
 tb/tb_fir_n_tap.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_pkg : shared types, default widths and saturation helper for fir_n_tap |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fir_pkg;

  localparam int FIR_DATA_W     = 16;
  localparam int FIR_COEFF_W    = 16;
  localparam int FIR_ACC_W      = 16;
  localparam int FIR_FRAC_SHIFT = FIR_COEFF_W - 1;
  localparam int FIR_WIDE_W     = 64;

  typedef logic signed [FIR_DATA_W-1:0]  sample_t;
  typedef logic signed [FIR_COEFF_W-1:0] coeff_t;
  typedef logic signed [FIR_ACC_W-1:0]   acc_t;
  typedef logic signed [FIR_WIDE_W-1:0]  wide_t;

  // Clamp a wide signed value into the signed range of an acc_w-bit word; the
  // result stays wide so callers can also compare it with the unclamped value.
  function automatic wide_t sat_acc(input wide_t v, input int unsigned acc_w);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    min_v = -max_v - wide_t'(1);
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coeff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_coeff_bank : double-buffered coefficients, shadow written, committed   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_coeff_bank #(
  parameter int N_TAPS  = 8,
  parameter int COEFF_W = 16,
  parameter int ADDR_W  = $clog2(N_TAPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic signed [COEFF_W-1:0] data_i,
  input  logic                      commit_i,
  output logic signed [COEFF_W-1:0] active_o [N_TAPS]
);

  logic signed [COEFF_W-1:0] shadow_q [N_TAPS];
  logic signed [COEFF_W-1:0] shadow_d [N_TAPS];
  logic signed [COEFF_W-1:0] active_q [N_TAPS];

  // Addresses beyond N_TAPS-1 match no entry, so such writes drop silently.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < N_TAPS; k++) begin
      if (wr_i && (addr_i == ADDR_W'(k))) begin
        shadow_d[k] = data_i;
      end
    end
  end

  // The commit copies shadow_d so a write in the commit cycle is included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) begin
        active_q <= shadow_d;
      end
    end
  end

  assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/fir_n_tap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_n_tap : signed pipelined N-tap FIR slice with cascade and saturation.  |
// | Optional macro FIR_N_TAP_ROUND_EN selects round-half-up. Revision: 1.0     |
// +----------------------------------------------------------------------------+
module fir_n_tap #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int N_TAPS  = 8,
  parameter int ACC_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [DATA_W-1:0]     sample_in,
  input  logic signed [ACC_W-1:0]      acc_in,
  input  logic                         coeff_wr,
  input  logic [$clog2(N_TAPS)-1:0]    coeff_addr,
  input  logic signed [COEFF_W-1:0]    coeff_data,
  input  logic                         coeff_commit,
  output logic                         out_valid,
  output logic signed [DATA_W-1:0]     sample_out,
  output logic signed [ACC_W-1:0]      acc_out,
  output logic                         sat_flag,
  input  logic                         sat_clr
);

  import fir_pkg::*;

  localparam int ADDR_W       = $clog2(N_TAPS);
  localparam int PROD_W       = DATA_W + COEFF_W;
  localparam int SUM_W        = PROD_W + $clog2(N_TAPS);
  localparam int c_frac_shift = COEFF_W - 1;
`ifdef FIR_N_TAP_ROUND_EN
  localparam wide_t c_round = wide_t'(1) <<< (COEFF_W - 2);
`else
  localparam wide_t c_round = '0;
`endif

  logic signed [COEFF_W-1:0] coeff_act [N_TAPS];
  logic signed [DATA_W-1:0]  taps_q    [N_TAPS];
  logic signed [PROD_W-1:0]  prod_d    [N_TAPS];
  logic signed [PROD_W-1:0]  prod_q    [N_TAPS];
  logic signed [ACC_W-1:0]   acc_in_q;
  logic signed [DATA_W-1:0]  casc_q;
  logic                      v1_q;

  logic                      out_valid_q;
  logic signed [DATA_W-1:0]  sample_out_q;
  logic signed [ACC_W-1:0]   acc_out_q;
  logic                      sat_flag_q;

  logic signed [SUM_W-1:0]   sum_w;
  wide_t                     shifted_w;
  wide_t                     total_w;
  wide_t                     sat_w;
  logic                      clip_w;

  fir_coeff_bank #(
    .N_TAPS  (N_TAPS),
    .COEFF_W (COEFF_W),
    .ADDR_W  (ADDR_W)
  ) u_coeff_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_i     (coeff_wr),
    .addr_i   (coeff_addr),
    .data_i   (coeff_data),
    .commit_i (coeff_commit),
    .active_o (coeff_act)
  );

  // Products use the taps before this cycle's shift; tap 0 sees the new sample.
  always_comb begin
    prod_d[0] = PROD_W'(sample_in) * PROD_W'(coeff_act[0]);
    for (int k = 1; k < N_TAPS; k++) begin
      prod_d[k] = PROD_W'(taps_q[k-1]) * PROD_W'(coeff_act[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        taps_q[k] <= '0;
        prod_q[k] <= '0;
      end
      acc_in_q <= '0;
      casc_q   <= '0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        taps_q[0] <= sample_in;
        for (int k = 1; k < N_TAPS; k++) begin
          taps_q[k] <= taps_q[k-1];
        end
        prod_q   <= prod_d;
        acc_in_q <= acc_in;
        casc_q   <= taps_q[N_TAPS-1];
      end
    end
  end

  always_comb begin
    sum_w = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      sum_w = sum_w + SUM_W'(prod_q[k]);
    end
    shifted_w = (wide_t'(sum_w) + c_round) >>> c_frac_shift;
    total_w   = shifted_w + wide_t'(acc_in_q);
    sat_w     = sat_acc(total_w, ACC_W);
    clip_w    = (sat_w != total_w);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
      acc_out_q    <= '0;
      sat_flag_q   <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        acc_out_q    <= sat_w[ACC_W-1:0];
        sample_out_q <= casc_q;
      end
      if (v1_q && clip_w) begin
        sat_flag_q <= 1'b1;
      end else if (sat_clr) begin
        sat_flag_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign sample_out = sample_out_q;
  assign acc_out    = acc_out_q;
  assign sat_flag   = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_n_tap.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_n_tap : scoreboard bench for fir_n_tap (N_TAPS=4) vs arithmetic model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_n_tap;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 4;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic signed [AW-1:0] acc_in = '0;
  logic                 coeff_wr = 1'b0;
  logic [1:0]           coeff_addr = '0;
  logic signed [CW-1:0] coeff_data = '0;
  logic                 coeff_commit = 1'b0;
  logic                 sat_clr = 1'b0;
  logic                 out_valid;
  logic signed [DW-1:0] sample_out;
  logic signed [AW-1:0] acc_out;
  logic                 sat_flag;

  fir_n_tap #(.DATA_W(DW), .COEFF_W(CW), .N_TAPS(NT), .ACC_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .sample_in    (sample_in),
    .acc_in       (acc_in),
    .coeff_wr     (coeff_wr),
    .coeff_addr   (coeff_addr),
    .coeff_data   (coeff_data),
    .coeff_commit (coeff_commit),
    .out_valid    (out_valid),
    .sample_out   (sample_out),
    .acc_out      (acc_out),
    .sat_flag     (sat_flag),
    .sat_clr      (sat_clr)
  );

  typedef struct {
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] samp;
    bit                   clip;
    int                   due;
  } exp_t;

  exp_t                 q[$];
  logic signed [AW-1:0] obs[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int hist[NT];
  int shadow[NT];
  int active[NT];

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc_n);
    end
  endfunction

  // Filter defined directly from its arithmetic: history, dot product, scale, clamp.
  task automatic model_edge();
    longint s;
    longint y;
    longint lim_hi;
    longint lim_lo;
    exp_t   e;
    cyc_n++;
    if (!rst_n) begin
      for (int k = 0; k < NT; k++) begin
        hist[k] = 0; shadow[k] = 0; active[k] = 0;
      end
      q.delete();
      return;
    end
    if (in_valid) begin
      s = longint'(sample_in) * longint'(active[0]);
      for (int k = 1; k < NT; k++) s += longint'(hist[k-1]) * longint'(active[k]);
`ifdef FIR_N_TAP_ROUND_EN
      s += longint'(1) <<< (CW - 2);
`endif
      y = (s >>> (CW - 1)) + longint'(acc_in);
      lim_hi = (longint'(1) <<< (AW - 1)) - 1;
      lim_lo = -lim_hi - 1;
      e.clip = (y > lim_hi) || (y < lim_lo);
      if (y > lim_hi) y = lim_hi;
      if (y < lim_lo) y = lim_lo;
      e.acc  = AW'(y);
      e.samp = DW'(hist[NT-1]);
      e.due  = cyc_n + 1;
      q.push_back(e);
      for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(sample_in);
    end
    if (coeff_wr && (int'(coeff_addr) < NT)) shadow[coeff_addr] = int'(coeff_data);
    if (coeff_commit) active = shadow;
  endtask

  task automatic cyc(bit v, int s, int a, bit wr = 0, int addr = 0, int d = 0,
                     bit com = 0, bit clr = 0, bit rst = 1);
    rst_n        = rst;
    in_valid     = v;
    sample_in    = DW'(s);
    acc_in       = AW'(a);
    coeff_wr     = wr;
    coeff_addr   = 2'(addr);
    coeff_data   = CW'(d);
    coeff_commit = com;
    sat_clr      = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic load4(int c0, int c1, int c2, int c3);
    cyc(0, 0, 0, 1, 0, c0);
    cyc(0, 0, 0, 1, 1, c1);
    cyc(0, 0, 0, 1, 2, c2);
    cyc(0, 0, 0, 1, 3, c3, 1);
  endtask

  // Monitor: inputs seen at a falling edge are the ones the next rising edge samples.
  bit   rst_pend = 1'b0;
  bit   clr_pend = 1'b0;
  bit   flag_m   = 1'b0;
  bit   clip_now;
  exp_t mon_e;

  always @(negedge clk) begin
    clip_now = 1'b0;
    if (out_valid) obs.push_back(acc_out);
    if (!rst_pend) begin
      flag_m = 1'b0;
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_acc_out", longint'(acc_out), 0);
      check("reset_sample_out", longint'(sample_out), 0);
      check("reset_sat_flag", longint'(sat_flag), 0);
    end else begin
      while (q.size() > 0 && q[0].due < cyc_n) begin
        check("missing_out_valid", 0, 1);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0 || q[0].due != cyc_n) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("acc_out", longint'(acc_out), longint'(mon_e.acc));
          check("sample_out", longint'(sample_out), longint'(mon_e.samp));
          clip_now = mon_e.clip;
        end
      end
      if (clip_now) flag_m = 1'b1;
      else if (clr_pend) flag_m = 1'b0;
      check("sat_flag", longint'(sat_flag), longint'(flag_m));
    end
    rst_pend = rst_n;
    clr_pend = sat_clr;
  end

  int imp_exp[4];

  initial begin
`ifdef FIR_N_TAP_ROUND_EN
    imp_exp = '{32'h4000, 32'h2000, 32'h1000, 32'h0800};
`else
    imp_exp = '{32'h3FFF, 32'h1FFF, 32'h0FFF, 32'h07FF};
`endif
    for (int k = 0; k < NT; k++) begin
      hist[k] = 0; shadow[k] = 0; active[k] = 0;
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Impulse response
    load4('h4000, 'h2000, 'h1000, 'h0800);
    obs.delete();
    cyc(1, 'h7FFF, 0);
    repeat (4) cyc(1, 0, 0);
    idle(3);
    check("impulse_count", obs.size(), 5);
    for (int k = 0; k < 4; k++) check($sformatf("impulse_%0d", k), longint'(obs[k]), imp_exp[k]);

    // Positive and negative saturation with sticky flag
    load4('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF);
    obs.delete();
    repeat (4) cyc(1, 'h7FFF, 0);
    idle(3);
    check("sat_pos_value", longint'(obs[3]), 32767);
    check("sat_pos_flag", longint'(sat_flag), 1);
    idle(5);
    check("sat_flag_sticky", longint'(sat_flag), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    check("sat_flag_cleared", longint'(sat_flag), 0);
    obs.delete();
    repeat (4) cyc(1, 'h8000, 0);
    idle(3);
    check("sat_neg_value", longint'(obs[3]), -32768);
    check("sat_neg_flag", longint'(sat_flag), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Cascade path with zero coefficients
    load4(0, 0, 0, 0);
    obs.delete();
    cyc(1, 'h0101, 'h1234);
    cyc(1, 'h0202, 'h1234);
    cyc(1, 'h0303, 'h1234);
    cyc(1, 'h0404, 'h1234);
    cyc(1, 'h0505, 'h1234);
    idle(3);
    check("cascade_acc", longint'(obs[0]), 'h1234);

    // Stall pattern 1,0,0,1
    load4('h4000, 'h2000, 'h1000, 'h0800);
    obs.delete();
    cyc(1, 'h1111, 0);
    idle(2);
    cyc(1, -'h2222, 0);
    idle(3);
    check("stall_pulses", obs.size(), 2);

    // Shadow write without commit, then commit alongside a sample
    cyc(1, 'h0800, 0, 1, 0, 'h7FFF);
    cyc(1, 'h0900, 0);
    cyc(1, 'h0A00, 0, 0, 0, 0, 1);
    cyc(1, 'h0B00, 0);
    idle(3);

    // Reset while outputs are in flight, then impulse with cleared coefficients
    cyc(1, 'h7FFF, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    obs.delete();
    cyc(1, 'h7FFF, 0);
    idle(3);
    check("post_reset_impulse", longint'(obs[0]), 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), int'($urandom),
          ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 511)) - 256,
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 499) != 0));
    end
    idle(4);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
